encrypted_byte_framer: RTL



---
 rtl/cipher_frame_pkg.sv | 25 ++
 rtl/byte_fifo.sv | 62 ++++++
 rtl/encrypted_byte_framer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cipher_frame_pkg.sv
// rtl/cipher_frame_pkg.sv - shared byte width, frame marker and framer state encoding
package cipher_frame_pkg;

  // Byte width shared by the encryptor, decryptor and framer datapaths.
  localparam int BYTE_W = 8;

  // Start-of-frame marker placed at the head of every frame.
  localparam logic [BYTE_W-1:0] SOF_BYTE = 8'hA5;

  // Framer state encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SOF     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_SOF     = ST_SOF,
    S_LEN     = ST_LEN,
    S_PAYLOAD = ST_PAYLOAD,
    S_CSUM    = ST_CSUM
  } frame_state_t;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - power-of-two byte FIFO with occupancy count
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (flushes the FIFO)
//   push, din  : write request and data (ignored while full)
//   pop, dout  : read request (ignored while empty) and current head entry
//   count      : entries held, 0..DEPTH
//   full/empty : occupancy flags
module byte_fifo
  import cipher_frame_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [BYTE_W-1:0]        din,
  output logic [BYTE_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/encrypted_byte_framer.sv
// rtl/encrypted_byte_framer.sv - buffers encrypted bytes and emits SOF/LEN/payload/checksum frames
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset (aborts any frame in flight)
//   in_data/in_valid/in_ready: byte input handshake; in_ready is !fifo_full
//   out_data/out_valid/
//   out_ready                : framed byte output handshake
//   out_sof / out_eof        : marks the SOF beat / the checksum beat
//   frame_count              : frames completed since reset, wrapping
module encrypted_byte_framer #(
  parameter int          FRAME_LEN  = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [7:0]  SOF_BYTE   = cipher_frame_pkg::SOF_BYTE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic [15:0] frame_count
);

  import cipher_frame_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  frame_state_t      state;
  frame_state_t      state_next;
  logic [7:0]        byte_cnt;
  logic [7:0]        csum;
  logic [BYTE_W-1:0] fifo_dout;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              have_frame;
  logic              beat;
  logic              last_byte;

  assign in_ready   = !fifo_full;
  assign fifo_push  = in_valid && in_ready;
  assign have_frame = (fifo_count >= CW'(FRAME_LEN));
  assign beat       = out_valid && out_ready;
  assign last_byte  = (byte_cnt == 8'(FRAME_LEN - 1));
  // A frame only starts with FRAME_LEN bytes buffered, so the FIFO is never
  // empty in PAYLOAD; the empty guard just keeps the pop well-defined.
  assign fifo_pop   = beat && (state == S_PAYLOAD) && !fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      csum        <= '0;
      frame_count <= '0;
    end else begin
      state <= state_next;
      if (state_next == S_SOF && state != S_SOF) begin
        csum     <= '0;
        byte_cnt <= '0;
      end else if (fifo_pop) begin
        csum     <= csum ^ fifo_dout;
        byte_cnt <= last_byte ? 8'd0 : byte_cnt + 8'd1;
      end
      if (state == S_CSUM && beat) begin
        frame_count <= frame_count + 16'd1;
      end
    end
  end

  // Outputs decode only from registered state, so they cannot change while
  // a beat is stalled (the FIFO head only moves on a pop).
  always_comb begin
    state_next = state;
    out_valid  = 1'b0;
    out_sof    = 1'b0;
    out_eof    = 1'b0;
    out_data   = '0;
    case (state)
      S_IDLE: begin
        if (have_frame) state_next = S_SOF;
      end
      S_SOF: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_data  = SOF_BYTE;
        if (beat) state_next = S_LEN;
      end
      S_LEN: begin
        out_valid = 1'b1;
        out_data  = 8'(FRAME_LEN);
        if (beat) state_next = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        out_valid = 1'b1;
        out_data  = fifo_dout;
        if (beat && last_byte) state_next = S_CSUM;
      end
      S_CSUM: begin
        out_valid = 1'b1;
        out_eof   = 1'b1;
        out_data  = csum;
        if (beat) state_next = have_frame ? S_SOF : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule
